// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial front end for the sequence detector. WIDTH-bit words are
// accepted over a valid/ready handshake and emitted one bit at a time on
// seq_out, each bit held for BIT_DIV clocks. A new word may be accepted on the
// last clock of the current frame, so back-to-back words stream with no gap.
//
// Optional feature (compile-time macro):
//   SERIALIZER_PARITY_EN  - when defined, an even-parity bit (^word) follows
//                           the data bits, held BIT_DIV clocks. done and
//                           load_ready then fall on the parity bit's last clock.
//                           When undefined, no parity logic exists.
//
// Parameters:
//   WIDTH      data bits per word (>=2)
//   BIT_DIV    clocks each bit is held on seq_out (>=1)
//   MSB_FIRST  1: bit WIDTH-1 sent first, 0: bit 0 sent first
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   data_in     in   word to serialize, sampled on an accepted load
//   load_valid  in   data_in is valid
//   load_ready  out  block can accept a word this cycle (decoded, not from load_valid)
//   seq_out     out  serial bit (registered), feeds the detector's seq_in
//   seq_valid   out  seq_out carries a frame bit (registered)
//   busy        out  a frame is in progress (registered)
//   done        out  1-cycle pulse on the last clock of the last frame bit (decoded)
// -----------------------------------------------------------------------------
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int BIT_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FB = WIDTH + 1;
`else
    localparam int FB = WIDTH;
`endif

    localparam int BIT_W = $clog2(FB);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q,   state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic             seq_out_q, seq_out_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q,  parity_d;
`endif

    logic             last_clk;
    logic             bit_adv;
    logic             accept;
    logic [WIDTH-1:0] shift_next;
    logic             first_bit;
    logic             next_bit;

    // Frame-end decode drives both done and the reload window; accept depends
    // on load_ready, which itself never looks at load_valid.
    always_comb begin
        last_clk   = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && (div_cnt_q == DIV_LAST);
        bit_adv    = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
        load_ready = (state_q == IDLE) || last_clk;
        done       = last_clk;
        accept     = load_valid && load_ready;
    end

    // The output end of the shift register is the bit on the wire; the bit
    // behind it becomes the next seq_out when the current bit finishes.
    always_comb begin
        shift_next = shift_q;
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
            first_bit  = data_in[WIDTH-1];
            next_bit   = shift_q[WIDTH-2];
        end else begin
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
            first_bit  = data_in[0];
            next_bit   = shift_q[1];
        end
`ifdef SERIALIZER_PARITY_EN
        // After the final data bit the parity bit goes out instead.
        if (bit_cnt_q == DATA_LAST) begin
            next_bit = parity_q;
        end
`endif
    end

    // Next-state logic. An accept always wins, which covers both the idle
    // start and the gapless reload on the last clock of a frame.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        seq_out_d = seq_out_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            state_d   = SHIFT;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = data_in;
            seq_out_d = first_bit;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_d  = ^data_in;
`endif
        end else if (last_clk) begin
            state_d   = IDLE;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            seq_out_d = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
        end else if (bit_adv) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_next;
            seq_out_d = next_bit;
        end else if (state_q == SHIFT) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // All state and registered outputs; reset aborts any frame silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            seq_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            seq_out_q <= seq_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign seq_out   = seq_out_q;
    assign seq_valid = valid_q;
    assign busy      = busy_q;

endmodule
